altera_ddr_ex_lfsr8_checker: RTL and testbench

Read-side data checker for the DDR example driver. It regenerates, per 8-bit byte lane, the same LFSR pattern sequence the write-side generator produces, then compares it against words returned by the controller. It reports sticky per-lane mismatch flags, an error count, first-failure capture and pass/fail status. It sits between the controller's local read-data port and the example driver's status outputs.

---
 rtl/altera_ddr_ex_lfsr8_checker.sv | 128 ++++++++++++
 tb/tb_altera_ddr_ex_lfsr8_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/altera_ddr_ex_lfsr8_checker.sv
// Read-side LFSR pattern checker: regenerates per-lane byte sequences and scores returned words.
// Latency: one cycle from an accepted word to updated expected/err_* outputs.
// Backpressure: none; words are taken whenever rd_valid is high in CHECK, gaps pause the LFSRs.
module altera_ddr_ex_lfsr8_checker #(
    parameter logic [31:0] seed      = 32'h0,
    parameter int          LANES     = 4,
    parameter int          NUM_WORDS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 rd_valid,
    input  logic [8*LANES-1:0]   rd_data,
    output logic [8*LANES-1:0]   expected,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [LANES-1:0]     err_lanes,
    output logic [15:0]          err_count,
    output logic [15:0]          first_err_idx,
    output logic [8*LANES-1:0]   first_err_data
);

    localparam int DW = 8 * LANES;

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

    function automatic logic [DW-1:0] lane_seeds();
        logic [DW-1:0] w;
        logic [31:0]   s;
        w = '0;
        for (int i = 0; i < LANES; i++) begin
            s = seed + 32'(i);
            w[8*i +: 8] = s[7:0];
        end
        return w;
    endfunction

    // Must stay bit-identical to the write-side generator.
    function automatic logic [7:0] lfsr_step(input logic [7:0] d);
        return {d[6:0], d[7]} ^ {3'b000, d[7], d[7], d[7], 2'b00};
    endfunction

    localparam logic [DW-1:0] SEEDS = lane_seeds();

    state_t            state, state_nxt;
    logic [DW-1:0]     lfsr, lfsr_nxt;
    logic [15:0]       word_idx;
    logic              first_seen;
    logic [LANES-1:0]  lane_mm;
    logic              accept, load, last_word;

    assign accept    = (state == CHECK) && rd_valid;
    assign load      = (state != CHECK) && start;
    assign last_word = (word_idx == 16'(NUM_WORDS - 1));

    always_comb begin
        lane_mm  = '0;
        lfsr_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mm[i]          = (rd_data[8*i +: 8] != lfsr[8*i +: 8]);
            lfsr_nxt[8*i +: 8]  = lfsr_step(lfsr[8*i +: 8]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nxt = CHECK;
                CHECK:      if (rd_valid && last_word) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // Disable and a fresh start share the same clear/reload path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr           <= SEEDS;
            word_idx       <= '0;
            err_lanes      <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            first_seen     <= 1'b0;
        end else if (!enable || load) begin
            lfsr           <= SEEDS;
            word_idx       <= '0;
            err_lanes      <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            first_seen     <= 1'b0;
        end else if (accept) begin
            err_lanes <= err_lanes | lane_mm;
            if (|lane_mm) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (!first_seen) begin
                    first_err_idx  <= word_idx;
                    first_err_data <= rd_data;
                    first_seen     <= 1'b1;
                end
            end
            lfsr     <= lfsr_nxt;
            word_idx <= word_idx + 16'd1;
        end
    end

    assign expected = lfsr;
    assign busy     = (state == CHECK);
    assign done     = (state == DONE);
    assign pass     = done && (err_count == 16'd0);

endmodule

// File: tb/tb_altera_ddr_ex_lfsr8_checker.sv
// Bench for the LFSR read checker: directed and randomized runs scored against a polynomial-level model.
`timescale 1ns/1ps
module tb_altera_ddr_ex_lfsr8_checker;

    localparam logic [31:0] SEED   = 32'h20;
    localparam logic [31:0] SEED_B = 32'h1FE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, start, rd_valid;
    logic [31:0] rd_data, expected, first_err_data;
    logic        busy, done, pass;
    logic [3:0]  err_lanes;
    logic [15:0] err_count, first_err_idx;

    logic        enable_b, start_b, rd_valid_b;
    logic [31:0] rd_data_b, expected_b, first_err_data_b;
    logic        busy_b, done_b, pass_b;
    logic [3:0]  err_lanes_b;
    logic [15:0] err_count_b, first_err_idx_b;

    altera_ddr_ex_lfsr8_checker #(.seed(SEED), .LANES(4), .NUM_WORDS(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .rd_valid(rd_valid), .rd_data(rd_data), .expected(expected),
        .busy(busy), .done(done), .pass(pass), .err_lanes(err_lanes),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_data(first_err_data)
    );

    altera_ddr_ex_lfsr8_checker #(.seed(SEED_B), .LANES(4), .NUM_WORDS(65535)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b), .start(start_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .expected(expected_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_lanes(err_lanes_b),
        .err_count(err_count_b), .first_err_idx(first_err_idx_b),
        .first_err_data(first_err_data_b)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state
    logic [7:0]  m_lane [4];
    logic [7:0]  b_lane [4];
    int          m_cnt, m_idx;
    logic [3:0]  m_err;
    logic        m_seen;
    logic [15:0] m_fidx;
    logic [31:0] m_fdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Galois form of the byte LFSR: x^8 + x^4 + x^3 + x^2 + 1.
    function automatic logic [7:0] nxt(input logic [7:0] d);
        return {d[6:0], 1'b0} ^ (d[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [31:0] seeds_of(input logic [31:0] s);
        logic [31:0] w, t;
        for (int i = 0; i < 4; i++) begin
            t = s + 32'(i);
            w[8*i +: 8] = t[7:0];
        end
        return w;
    endfunction

    function automatic logic [31:0] mword();
        return {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
    endfunction

    task automatic start_run();
        logic [31:0] s;
        s = seeds_of(SEED);
        for (int i = 0; i < 4; i++) m_lane[i] = s[8*i +: 8];
        m_cnt = 0; m_idx = 0; m_err = '0; m_seen = 1'b0; m_fidx = '0; m_fdata = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_expected", 64'(expected), 64'(mword()));
    endtask

    task automatic send(input logic [31:0] flip, input int gap, input bit st);
        for (int g = 0; g < gap; g++) begin
            rd_data = $urandom;
            tick();
            chk("gap_hold_expected", 64'(expected), 64'(mword()));
            chk("gap_busy", 64'(busy), 64'(1));
        end
        chk("pre_expected", 64'(expected), 64'(mword()));
        rd_data  = mword() ^ flip;
        rd_valid = 1'b1;
        start    = st;
        tick();
        rd_valid = 1'b0;
        start    = 1'b0;
        if (flip != 0) begin
            if (m_cnt < 65535) m_cnt++;
            for (int i = 0; i < 4; i++) if (flip[8*i +: 8] != 8'h00) m_err[i] = 1'b1;
            if (!m_seen) begin
                m_seen  = 1'b1;
                m_fidx  = 16'(m_idx);
                m_fdata = mword() ^ flip;
            end
        end
        m_idx++;
        for (int i = 0; i < 4; i++) m_lane[i] = nxt(m_lane[i]);
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_pass"}, 64'(pass), 64'(m_cnt == 0));
        chk({tag, "_err_count"}, 64'(err_count), 64'(m_cnt));
        chk({tag, "_err_lanes"}, 64'(err_lanes), 64'(m_err));
        chk({tag, "_first_idx"}, 64'(first_err_idx), 64'(m_fidx));
        chk({tag, "_first_data"}, 64'(first_err_data), 64'(m_fdata));
    endtask

    task automatic check_idle_cleared(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_pass"}, 64'(pass), 64'(0));
        chk({tag, "_expected"}, 64'(expected), 64'(seeds_of(SEED)));
        chk({tag, "_err_count"}, 64'(err_count), 64'(0));
        chk({tag, "_err_lanes"}, 64'(err_lanes), 64'(0));
        chk({tag, "_first_idx"}, 64'(first_err_idx), 64'(0));
        chk({tag, "_first_data"}, 64'(first_err_data), 64'(0));
    endtask

    initial begin
        logic [31:0] flip, bw, b_first;
        logic [3:0]  b_err;
        int          ln;

        reset = 1'b1; enable = 1'b1; start = 1'b0; rd_valid = 1'b0; rd_data = '0;
        enable_b = 1'b1; start_b = 1'b0; rd_valid_b = 1'b0; rd_data_b = '0;
        tick();
        tick();
        check_idle_cleared("reset");
        chk("reset_b_expected", 64'(expected_b), 64'(32'h0100FFFE));
        reset = 1'b0;
        tick();
        check_idle_cleared("idle_hold");

        // Error-free back-to-back run
        start_run();
        for (int k = 0; k < 4; k++) send(32'h0, 0, 1'b0);
        check_results("clean");

        // rd_valid in DONE is ignored
        rd_data = ~mword(); rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        check_results("done_ignore");
        chk("done_ignore_expected", 64'(expected), 64'(mword()));

        // Single bit error: lane 2 bit 3 of word 2
        start_run();
        for (int k = 0; k < 4; k++) send((k == 2) ? 32'h0008_0000 : 32'h0, 0, 1'b0);
        check_results("single_bit");
        chk("single_bit_lanes_const", 64'(err_lanes), 64'(4'b0100));

        // Pause: 5 idle cycles between words
        start_run();
        for (int k = 0; k < 4; k++) send(32'h0, (k == 0) ? 0 : 5, 1'b0);
        check_results("pause");

        // Randomized runs, restarted from DONE each time
        for (int r = 0; r < 8; r++) begin
            start_run();
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 2))
                    0:       flip = 32'h1 << $urandom_range(0, 31);
                    1:       flip = $urandom;
                    default: flip = 32'h0;
                endcase
                send(flip, $urandom_range(0, 3), 1'b0);
            end
            check_results("random");
        end

        // start during CHECK is ignored
        start_run();
        send(32'h0, 0, 1'b0);
        send(32'h0000_0001, 0, 1'b1);
        send(32'h0, 0, 1'b0);
        chk("start_in_check_busy", 64'(busy), 64'(1));
        send(32'h0, 0, 1'b0);
        check_results("start_in_check");

        // enable low mid-run with rd_valid high
        start_run();
        send(32'hFF00_0000, 0, 1'b0);
        send(32'h0000_0010, 0, 1'b0);
        chk("pre_disable_count", 64'(err_count), 64'(2));
        enable = 1'b0; rd_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
        tick();
        rd_valid = 1'b0;
        check_idle_cleared("disable");
        enable = 1'b1;
        tick();
        check_idle_cleared("reenable");

        // Async reset pulse shorter than a clock, mid-run
        start_run();
        send(32'h0000_0300, 0, 1'b0);
        send(32'h0, 0, 1'b0);
        #1 reset = 1'b1;
        #1 check_idle_cleared("async_reset");
        #1 reset = 1'b0;
        tick();
        start_run();
        for (int k = 0; k < 4; k++) send(32'h0, 0, 1'b0);
        check_results("after_reset");

        // Saturation: 65535 words, every one corrupted
        for (int i = 0; i < 4; i++) begin
            bw = seeds_of(SEED_B);
            b_lane[i] = bw[8*i +: 8];
        end
        b_err = '0; b_first = '0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("sat_busy", 64'(busy_b), 64'(1));
        for (int k = 0; k < 65535; k++) begin
            if (k == 65534) begin
                chk("sat_last_busy", 64'(busy_b), 64'(1));
                chk("sat_last_done", 64'(done_b), 64'(0));
            end
            ln   = $urandom_range(0, 3);
            flip = 32'h1 << (8 * ln + $urandom_range(0, 7));
            b_err[ln] = 1'b1;
            bw = {b_lane[3], b_lane[2], b_lane[1], b_lane[0]};
            if (k == 0) b_first = bw ^ flip;
            rd_data_b  = bw ^ flip;
            rd_valid_b = 1'b1;
            tick();
            for (int i = 0; i < 4; i++) b_lane[i] = nxt(b_lane[i]);
        end
        rd_valid_b = 1'b0;
        chk("sat_done", 64'(done_b), 64'(1));
        chk("sat_busy_end", 64'(busy_b), 64'(0));
        chk("sat_pass", 64'(pass_b), 64'(0));
        chk("sat_err_count", 64'(err_count_b), 64'(16'hFFFF));
        chk("sat_first_idx", 64'(first_err_idx_b), 64'(0));
        chk("sat_first_data", 64'(first_err_data_b), 64'(b_first));
        chk("sat_err_lanes", 64'(err_lanes_b), 64'(b_err));
        chk("sat_expected", 64'(expected_b), 64'({b_lane[3], b_lane[2], b_lane[1], b_lane[0]}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
